// File: rtl/traffic_light_monitor.sv
// Protocol checker for a two-direction traffic light: tracks each direction's lamp
// phase and flags encoding, conflict, ordering and phase-duration violations.
module traffic_light_monitor #(
    parameter int unsigned YELLOW_LEN = 5,
    parameter int unsigned MIN_GREEN  = 10,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 clear_err,
    input  logic                 Ga,
    input  logic                 Ya,
    input  logic                 Ra,
    input  logic                 Gb,
    input  logic                 Yb,
    input  logic                 Rb,
    output logic                 err,
    output logic [2:0]           err_code,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {PH_G, PH_Y, PH_R} phase_e;

    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_ENCODING   = 3'd1,
        ERR_CONFLICT   = 3'd2,
        ERR_ORDER      = 3'd3,
        ERR_YELLOW_LEN = 3'd4,
        ERR_MIN_GREEN  = 3'd5
    } err_code_e;

    typedef struct packed {
        phase_e           phase;
        logic             prev_valid;
        logic             partial;
        logic [CNT_W-1:0] run;
    } dir_state_t;

    localparam logic [CNT_W-1:0]     YEL_LEN_C   = CNT_W'(YELLOW_LEN);
    localparam logic [CNT_W-1:0]     MIN_GREEN_C = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0]     RUN_ONE     = CNT_W'(1);
    localparam logic [ERR_CNT_W-1:0] ERR_ONE     = ERR_CNT_W'(1);

    // Input sample stage: lamps are registered first, so checks see the previous edge's sample.
    logic [1:0][2:0]      lamps_q;
    logic                 sample_en_q;

    dir_state_t           dir_q [2];
    dir_state_t           dir_d [2];
    logic                 legal [2];
    phase_e               cur   [2];
    logic [5:1]           viol;
    logic                 viol_any;
    logic [2:0]           first_code;

    logic                 err_q, err_d;
    logic [2:0]           err_code_q, err_code_d;
    logic                 err_pulse_q, err_pulse_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            legal[d] = (lamps_q[d] == 3'b100) || (lamps_q[d] == 3'b010) || (lamps_q[d] == 3'b001);
            cur[d]   = lamps_q[d][2] ? PH_G : (lamps_q[d][1] ? PH_Y : PH_R);
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        dir_d = dir_q;
        viol  = '0;
        for (int d = 0; d < 2; d++) begin
            if (!sample_en_q) begin
                dir_d[d].prev_valid = 1'b0;
            end else if (!legal[d]) begin
                viol[ERR_ENCODING]  = 1'b1;
                dir_d[d].prev_valid = 1'b0;
            end else if (!dir_q[d].prev_valid) begin
                // Resync: history is unknown, so duration/order checks wait for a clean change.
                dir_d[d].phase      = cur[d];
                dir_d[d].prev_valid = 1'b1;
                dir_d[d].partial    = 1'b1;
                dir_d[d].run        = RUN_ONE;
            end else if (cur[d] == dir_q[d].phase) begin
                if (dir_q[d].run != '1) begin
                    dir_d[d].run = dir_q[d].run + RUN_ONE;
                end
                if (!dir_q[d].partial && cur[d] == PH_Y && dir_q[d].run == YEL_LEN_C) begin
                    viol[ERR_YELLOW_LEN] = 1'b1;
                end
            end else begin
                dir_d[d].phase   = cur[d];
                dir_d[d].partial = 1'b0;
                dir_d[d].run     = RUN_ONE;
                if (!dir_q[d].partial) begin
                    if (!((dir_q[d].phase == PH_G && cur[d] == PH_Y) ||
                          (dir_q[d].phase == PH_Y && cur[d] == PH_R) ||
                          (dir_q[d].phase == PH_R && cur[d] == PH_G))) begin
                        viol[ERR_ORDER] = 1'b1;
                    end
                    if (dir_q[d].phase == PH_Y && dir_q[d].run < YEL_LEN_C) begin
                        viol[ERR_YELLOW_LEN] = 1'b1;
                    end
                    if (dir_q[d].phase == PH_G && cur[d] == PH_Y && dir_q[d].run < MIN_GREEN_C) begin
                        viol[ERR_MIN_GREEN] = 1'b1;
                    end
                end
            end
        end
        if (sample_en_q && legal[0] && legal[1] && cur[0] != PH_R && cur[1] != PH_R) begin
            viol[ERR_CONFLICT] = 1'b1;
        end
    end

    always_comb begin
        first_code = ERR_NONE;
        for (int c = 5; c >= 1; c--) begin
            if (viol[c]) begin
                first_code = 3'(c);
            end
        end
        viol_any = |viol;

        err_d       = err_q;
        err_code_d  = err_code_q;
        err_count_d = err_count_q;
        err_pulse_d = viol_any;
        if (clear_err) begin
            // A violation landing on the clearing edge survives the clear.
            err_d       = viol_any;
            err_code_d  = viol_any ? first_code : ERR_NONE;
            err_count_d = viol_any ? ERR_ONE : '0;
        end else if (viol_any) begin
            err_d = 1'b1;
            if (!err_q) begin
                err_code_d = first_code;
            end
            if (err_count_q != '1) begin
                err_count_d = err_count_q + ERR_ONE;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only; all next-state math lives above.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lamps_q     <= '0;
            sample_en_q <= 1'b0;
            for (int d = 0; d < 2; d++) begin
                dir_q[d] <= '0;
            end
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            lamps_q     <= {{Gb, Yb, Rb}, {Ga, Ya, Ra}};
            sample_en_q <= enable;
            dir_q       <= dir_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign err       = err_q;
    assign err_code  = err_code_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

endmodule
